btb_update_ctrl: RTL and testbench
==================================

BTB_UPDATE_CTRL -- requirements
Module: btb_update_ctrl

Interface
REQ-001 Parameter BTB_SIZE, 64, number of BTB lines; power of two.
REQ-002 Parameter INDEX_W, 6, log2(BTB_SIZE).
REQ-003 Parameter ADDR_W, 32, PC/target width.
REQ-004 Parameter Q_DEPTH, 4, ID install queue depth; power of two, at least 2.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 id_valid  in  1  ID requests BTB install.
REQ-008 id_is_jump  in  1  ID entry is an unconditional jump.
REQ-009 id_pc, id_target  in  ADDR_W  ID branch PC and target.
REQ-010 id_ready  out  1  ID install accepted this cycle.
REQ-011 cm_valid  in  1  commit requests correction.
REQ-012 cm_invalidate  in  1  correction removes the line (writes valid=0).
REQ-013 cm_is_jump  in  1  commit jump flag.
REQ-014 cm_pc, cm_target  in  ADDR_W  commit PC and target.
REQ-015 cm_ready  out  1  commit correction accepted this cycle.
REQ-016 flush_req  in  1  one-cycle pulse; invalidate whole BTB.
REQ-017 flush_busy  out  1  flush walk in progress.
REQ-018 btb_we  out  1  BTB line write strobe.
REQ-019 btb_index  out  INDEX_W  line written.
REQ-020 btb_valid, btb_is_jump  out  1  line fields written.
REQ-021 btb_pc, btb_target  out  ADDR_W  line fields written.

Function
REQ-022 Line index of any PC SHALL be pc[INDEX_W+1:2].
REQ-023 All btb_* outputs SHALL be registered: a request accepted in cycle N produces btb_we in cycle N+1 at the earliest.
REQ-024 At most one BTB write SHALL issue per cycle; priority is flush walk, then commit, then queue head.
REQ-025 FSM states are IDLE and FLUSH; reset enters IDLE.
REQ-026 IDLE + flush_req: go to FLUSH, clear the queue, and set the walk counter to 0.
REQ-027 In FLUSH, each cycle SHALL write index=counter with valid=0 and then increment the counter.
REQ-028 After the write at BTB_SIZE-1, the FSM SHALL return to IDLE; the walk takes exactly BTB_SIZE write cycles.
REQ-029 flush_req during FLUSH SHALL restart the counter at 0.
REQ-030 flush_busy SHALL equal (state==FLUSH).
REQ-031 cm_ready SHALL equal (state==IDLE && !flush_req).
REQ-032 An accepted commit SHALL write in the next cycle: valid=!cm_invalidate, with its pc, target and is_jump.
REQ-033 id_ready SHALL equal (state==IDLE && !flush_req && queue not full).
REQ-034 Enqueue is not permitted when full, even if a dequeue happens in the same cycle.
REQ-035 Queue order SHALL be FIFO; the head issues with valid=1 only in cycles with no commit write pending.
REQ-036 An accepted commit to index X SHALL squash every queued entry, and any same-cycle ID enqueue, whose index equals X.
REQ-037 A squashed head SHALL be popped without a write and SHALL consume one cycle.
REQ-038 Queue pointers SHALL wrap modulo Q_DEPTH.
REQ-039 A separate count SHALL distinguish full from empty.

Reset
REQ-040 On rst low, asynchronously: state=IDLE, counter=0, queue empty, all squash bits 0, btb_we=0, all btb_* fields 0.
REQ-041 Reset asserted mid-flush or mid-drain SHALL abandon the operation; nothing resumes after reset is released.
REQ-042 While in reset, id_ready=0 and cm_ready=0; flush_busy=0.

Structure
REQ-043 A shared package SHALL hold BTB_SIZE, INDEX_W, ADDR_W, the FSM state encoding and the BTB write-request struct (valid, is_jump, pc, target, index).
REQ-044 The queue SHALL be one sub-module, btb_update_fifo, with a per-entry index-match squash port.

Verification
REQ-045 Reset then a single ID install (pc=0x00400010, target=0x00400100): next cycle btb_we=1, btb_index=4, btb_valid=1.
REQ-046 Four ID installs back-to-back with a blocked drain: id_ready=0 on the 5th; the writes then appear in issue order.
REQ-047 ID install queued at pc=0x00400010, then commit invalidate at pc=0x00400010: exactly one write (index 4, valid=0); the queued entry produces no write.
REQ-048 flush_req with BTB_SIZE=64: flush_busy high for 64 cycles, indices 0..63 each written once with valid=0, and cm_ready=0 throughout.
REQ-049 flush_req again at walk index 30: the walk restarts at 0 and totals 94 writes.
REQ-050 rst low at walk index 10: outputs clear immediately; after release, state=IDLE with no further writes.

Source files
------------

// File: rtl/btb_update_ctrl_pkg.sv
// Shared definitions for the BTB update controller.
//   BTB_SIZE / INDEX_W / ADDR_W : default geometry of the branch target buffer
//   state_e                     : controller FSM states (IDLE, FLUSH)
//   btb_wr_t                    : one BTB line write request
package btb_update_ctrl_pkg;

   localparam int unsigned BTB_SIZE = 64;
   localparam int unsigned INDEX_W  = 6;
   localparam int unsigned ADDR_W   = 32;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } state_e;

   typedef struct packed {
      logic               valid;
      logic               is_jump;
      logic [ADDR_W-1:0]  pc;
      logic [ADDR_W-1:0]  target;
      logic [INDEX_W-1:0] index;
   } btb_wr_t;

endpackage

// File: rtl/btb_update_fifo.sv
// Install queue for ID-stage BTB requests.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   clear_i           : drop every queued entry
//   push_*            : enqueue request (ignored while full, even if popping)
//   pop_i             : remove head entry
//   squash_i/_index_i : mark every entry (and a same-cycle push) whose line
//                       index matches, so it is later popped without a write
//   full_o, empty_o   : occupancy flags from a separate entry count
//   head_*            : head entry fields and its squash bit
module btb_update_fifo
   import btb_update_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = ADDR_W,
   parameter int unsigned IW    = INDEX_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear_i,
   input  logic          push_i,
   input  logic          push_is_jump_i,
   input  logic [AW-1:0] push_pc_i,
   input  logic [AW-1:0] push_target_i,
   input  logic          pop_i,
   input  logic          squash_i,
   input  logic [IW-1:0] squash_index_i,
   output logic          full_o,
   output logic          empty_o,
   output logic          head_is_jump_o,
   output logic [AW-1:0] head_pc_o,
   output logic [AW-1:0] head_target_o,
   output logic          head_squashed_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic [DEPTH-1:0] squash_q;
   logic [DEPTH-1:0] jump_mem_q;
   logic [AW-1:0]    pc_mem_q     [DEPTH];
   logic [AW-1:0]    target_mem_q [DEPTH];

   logic push_ok, pop_ok, push_squashed;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);

   // Push is judged against the pre-pop count: a full queue never accepts.
   assign push_ok       = push_i && !full_o && !clear_i;
   assign pop_ok        = pop_i && !empty_o && !clear_i;
   assign push_squashed = squash_i && (push_pc_i[IW+1:2] == squash_index_i);

   assign head_is_jump_o  = jump_mem_q[rd_ptr_q];
   assign head_pc_o       = pc_mem_q[rd_ptr_q];
   assign head_target_o   = target_mem_q[rd_ptr_q];
   assign head_squashed_o = squash_q[rd_ptr_q];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         squash_q <= '0;
      end else if (clear_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         squash_q <= '0;
      end else begin
         // Stale slots may also get marked; a push always rewrites its bit.
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (squash_i && (pc_mem_q[i][IW+1:2] == squash_index_i)) begin
               squash_q[i] <= 1'b1;
            end
         end
         if (push_ok) begin
            squash_q[wr_ptr_q] <= push_squashed;
            wr_ptr_q           <= wr_ptr_q + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         jump_mem_q[wr_ptr_q]   <= push_is_jump_i;
         pc_mem_q[wr_ptr_q]     <= push_pc_i;
         target_mem_q[wr_ptr_q] <= push_target_i;
      end
   end

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB update controller: arbitrates BTB line writes between a whole-table
// flush walk, commit-time corrections and queued ID-stage installs.
// Ports:
//   clk, rst                        : clock, asynchronous active-low reset
//   id_valid/_is_jump/_pc/_target   : ID install request, id_ready accepts
//   cm_valid/_invalidate/_is_jump/
//   cm_pc/_target                   : commit correction, cm_ready accepts
//   flush_req                       : pulse to invalidate the whole BTB
//   flush_busy                      : flush walk in progress
//   btb_we/_index/_valid/_is_jump/
//   btb_pc/_target                  : registered BTB line write port
// Write priority each cycle: flush walk, then commit, then queue head.
module btb_update_ctrl #(
   parameter int unsigned BTB_SIZE = btb_update_ctrl_pkg::BTB_SIZE,
   parameter int unsigned INDEX_W  = btb_update_ctrl_pkg::INDEX_W,
   parameter int unsigned ADDR_W   = btb_update_ctrl_pkg::ADDR_W,
   parameter int unsigned Q_DEPTH  = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               id_valid,
   input  logic               id_is_jump,
   input  logic [ADDR_W-1:0]  id_pc,
   input  logic [ADDR_W-1:0]  id_target,
   output logic               id_ready,
   input  logic               cm_valid,
   input  logic               cm_invalidate,
   input  logic               cm_is_jump,
   input  logic [ADDR_W-1:0]  cm_pc,
   input  logic [ADDR_W-1:0]  cm_target,
   output logic               cm_ready,
   input  logic               flush_req,
   output logic               flush_busy,
   output logic               btb_we,
   output logic [INDEX_W-1:0] btb_index,
   output logic               btb_valid,
   output logic               btb_is_jump,
   output logic [ADDR_W-1:0]  btb_pc,
   output logic [ADDR_W-1:0]  btb_target
);

   import btb_update_ctrl_pkg::*;

   state_e             state_q, state_d;
   logic [INDEX_W-1:0] walk_q, walk_d;
   logic               we_q, we_d;
   btb_wr_t            wr_q, wr_d;

   logic               cm_accept, id_accept, bypass;
   logic               q_push, q_pop, q_clear;
   logic               q_full, q_empty, q_head_jump, q_head_squashed;
   logic [ADDR_W-1:0]  q_head_pc, q_head_target;
   logic [INDEX_W-1:0] cm_index, walk_index;

   assign cm_index = cm_pc[INDEX_W+1:2];

   // rst gating keeps both readies low while reset is held.
   assign cm_ready   = rst && (state_q == ST_IDLE) && !flush_req;
   assign id_ready   = cm_ready && !q_full;
   assign flush_busy = (state_q == ST_FLUSH);

   assign cm_accept = cm_valid && cm_ready;
   assign id_accept = id_valid && id_ready;

   // An install into an empty queue with the write port free goes straight
   // to the write register; order is unaffected since nothing is queued.
   assign bypass = id_accept && !cm_accept && q_empty;
   assign q_push = id_accept && !bypass;

   always_comb begin
      state_d    = state_q;
      walk_d     = walk_q;
      we_d       = 1'b0;
      wr_d       = '0;
      q_pop      = 1'b0;
      q_clear    = 1'b0;
      walk_index = flush_req ? '0 : walk_q;
      case (state_q)
         ST_IDLE: begin
            if (flush_req) begin
               state_d = ST_FLUSH;
               walk_d  = '0;
               q_clear = 1'b1;
            end else if (cm_accept) begin
               we_d         = 1'b1;
               wr_d.valid   = !cm_invalidate;
               wr_d.is_jump = cm_is_jump;
               wr_d.pc      = cm_pc;
               wr_d.target  = cm_target;
               wr_d.index   = cm_index;
            end else if (!q_empty) begin
               // Squashed heads still take this cycle, just without a write.
               q_pop = 1'b1;
               if (!q_head_squashed) begin
                  we_d         = 1'b1;
                  wr_d.valid   = 1'b1;
                  wr_d.is_jump = q_head_jump;
                  wr_d.pc      = q_head_pc;
                  wr_d.target  = q_head_target;
                  wr_d.index   = q_head_pc[INDEX_W+1:2];
               end
            end else if (bypass) begin
               we_d         = 1'b1;
               wr_d.valid   = 1'b1;
               wr_d.is_jump = id_is_jump;
               wr_d.pc      = id_pc;
               wr_d.target  = id_target;
               wr_d.index   = id_pc[INDEX_W+1:2];
            end
         end
         ST_FLUSH: begin
            // A repeated flush_req restarts the walk with this cycle's write.
            we_d       = 1'b1;
            wr_d.index = walk_index;
            walk_d     = walk_index + 1'b1;
            q_clear    = flush_req;
            if ((walk_index == INDEX_W'(BTB_SIZE - 1)) && !flush_req) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         walk_q  <= '0;
         we_q    <= 1'b0;
         wr_q    <= '0;
      end else begin
         state_q <= state_d;
         walk_q  <= walk_d;
         we_q    <= we_d;
         wr_q    <= wr_d;
      end
   end

   assign btb_we      = we_q;
   assign btb_index   = wr_q.index;
   assign btb_valid   = wr_q.valid;
   assign btb_is_jump = wr_q.is_jump;
   assign btb_pc      = wr_q.pc;
   assign btb_target  = wr_q.target;

   btb_update_fifo #(
      .DEPTH (Q_DEPTH),
      .AW    (ADDR_W),
      .IW    (INDEX_W)
   ) u_fifo (
      .clk             (clk),
      .rst             (rst),
      .clear_i         (q_clear),
      .push_i          (q_push),
      .push_is_jump_i  (id_is_jump),
      .push_pc_i       (id_pc),
      .push_target_i   (id_target),
      .pop_i           (q_pop),
      .squash_i        (cm_accept),
      .squash_index_i  (cm_index),
      .full_o          (q_full),
      .empty_o         (q_empty),
      .head_is_jump_o  (q_head_jump),
      .head_pc_o       (q_head_pc),
      .head_target_o   (q_head_target),
      .head_squashed_o (q_head_squashed)
   );

endmodule

// File: tb/tb_btb_update_ctrl.sv
module tb_btb_update_ctrl;

   localparam int BTB = 64;
   localparam int QD  = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid, id_is_jump, cm_valid, cm_invalidate, cm_is_jump, flush_req;
   logic [31:0] id_pc, id_target, cm_pc, cm_target;
   logic        id_ready, cm_ready, flush_busy;
   logic        btb_we, btb_valid, btb_is_jump;
   logic [5:0]  btb_index;
   logic [31:0] btb_pc, btb_target;

   btb_update_ctrl #(
      .BTB_SIZE (BTB),
      .INDEX_W  (6),
      .ADDR_W   (32),
      .Q_DEPTH  (QD)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .id_valid      (id_valid),
      .id_is_jump    (id_is_jump),
      .id_pc         (id_pc),
      .id_target     (id_target),
      .id_ready      (id_ready),
      .cm_valid      (cm_valid),
      .cm_invalidate (cm_invalidate),
      .cm_is_jump    (cm_is_jump),
      .cm_pc         (cm_pc),
      .cm_target     (cm_target),
      .cm_ready      (cm_ready),
      .flush_req     (flush_req),
      .flush_busy    (flush_busy),
      .btb_we        (btb_we),
      .btb_index     (btb_index),
      .btb_valid     (btb_valid),
      .btb_is_jump   (btb_is_jump),
      .btb_pc        (btb_pc),
      .btb_target    (btb_target)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   // Reference model: flushing flag + walk position, and a plain queue of
   // pending installs each carrying a "killed by a later commit" flag.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] tgt;
      logic        jmp;
      bit          sq;
   } ent_t;

   ent_t mq[$];
   bit   m_flush;
   int   m_cnt;

   bit          e_we, e_flush;
   int          e_idx;
   logic        e_val, e_jmp;
   logic [31:0] e_pc, e_tgt;

   int   n_wr, n_busy, n_cmr;
   int   hits[BTB];
   int   wq[$];
   logic wvq[$];

   function automatic int line_of(input logic [31:0] pc);
      return int'((pc >> 2) % BTB);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_flush = 0;
      m_cnt   = 0;
      mq.delete();
   endtask

   task automatic set_write(input int idx, input logic v, input logic j,
                            input logic [31:0] pc, input logic [31:0] tgt, input bit fl);
      e_we = 1; e_idx = idx; e_val = v; e_jmp = j; e_pc = pc; e_tgt = tgt; e_flush = fl;
   endtask

   task automatic model_step(input bit id_rdy);
      bit   cm_acc, id_acc;
      int   i;
      ent_t h;
      e_we = 0; e_flush = 0;
      if (m_flush) begin
         i = flush_req ? 0 : m_cnt;
         set_write(i, 1'b0, 1'b0, '0, '0, 1);
         m_cnt = i + 1;
         if (i == BTB - 1 && !flush_req) m_flush = 0;
      end else if (flush_req) begin
         m_flush = 1;
         m_cnt   = 0;
         mq.delete();
      end else begin
         cm_acc = cm_valid;
         id_acc = id_valid && id_rdy;
         if (cm_acc) begin
            set_write(line_of(cm_pc), !cm_invalidate, cm_is_jump, cm_pc, cm_target, 0);
            foreach (mq[k]) if (line_of(mq[k].pc) == line_of(cm_pc)) mq[k].sq = 1;
         end
         if (id_acc)
            mq.push_back('{id_pc, id_target, id_is_jump,
                           cm_acc && (line_of(id_pc) == line_of(cm_pc))});
         if (!cm_acc && mq.size() > 0) begin
            h = mq.pop_front();
            if (!h.sq) set_write(line_of(h.pc), 1'b1, h.jmp, h.pc, h.tgt, 0);
         end
      end
   endtask

   // Inputs are set just after a rising edge; readies are checked before the
   // next edge, the resulting write just after it.
   task automatic tick();
      bit exp_cm, exp_id;
      #1;
      exp_cm = !m_flush && !flush_req;
      exp_id = exp_cm && (mq.size() < QD);
      check("cm_ready", cm_ready, exp_cm);
      check("id_ready", id_ready, exp_id);
      check("flush_busy", flush_busy, m_flush);
      if (flush_busy === 1'b1) begin
         n_busy++;
         if (cm_ready !== 1'b0) n_cmr++;
      end
      model_step(exp_id);
      @(posedge clk);
      #1;
      check("btb_we", btb_we, e_we);
      if (e_we) begin
         check("btb_index", btb_index, e_idx);
         check("btb_valid", btb_valid, e_val);
         if (!e_flush) begin
            check("btb_is_jump", btb_is_jump, e_jmp);
            check("btb_pc", btb_pc, e_pc);
            check("btb_target", btb_target, e_tgt);
         end
      end
      if (btb_we === 1'b1) begin
         n_wr++;
         wq.push_back(int'(btb_index));
         wvq.push_back(btb_valid);
         hits[btb_index]++;
      end
   endtask

   task automatic idle_inputs();
      id_valid = 0; id_is_jump = 0; id_pc = '0; id_target = '0;
      cm_valid = 0; cm_invalidate = 0; cm_is_jump = 0; cm_pc = '0; cm_target = '0;
      flush_req = 0;
   endtask

   task automatic clear_stats();
      n_wr = 0; n_busy = 0; n_cmr = 0;
      wq.delete(); wvq.delete();
      foreach (hits[k]) hits[k] = 0;
   endtask

   task automatic run_flush_to_end();
      for (int k = 0; k < 200 && m_flush; k++) tick();
      check("flush_terminates", m_flush, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad, c4, v4;
      idle_inputs();
      rst = 1'b0;
      model_reset();
      clear_stats();

      // Reset values while held
      #12;
      check("rst_btb_we", btb_we, 1'b0);
      check("rst_btb_index", btb_index, 6'd0);
      check("rst_btb_valid", btb_valid, 1'b0);
      check("rst_btb_pc", btb_pc, 32'd0);
      check("rst_btb_target", btb_target, 32'd0);
      check("rst_id_ready", id_ready, 1'b0);
      check("rst_cm_ready", cm_ready, 1'b0);
      check("rst_flush_busy", flush_busy, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;

      // Single install lands on the next cycle
      id_valid = 1; id_pc = 32'h0040_0010; id_target = 32'h0040_0100;
      tick();
      idle_inputs();
      check("single_we", btb_we, 1'b1);
      check("single_index", btb_index, 6'd4);
      check("single_valid", btb_valid, 1'b1);
      check("single_target", btb_target, 32'h0040_0100);
      tick();

      // Four installs while commits hold the write port; 5th is refused
      for (int k = 0; k < 5; k++) begin
         id_valid = 1; id_is_jump = k[0];
         id_pc = 32'h0040_0000 + 32'(4 * (k + 1)); id_target = 32'h0050_0000 + 32'(k);
         cm_valid = 1; cm_pc = 32'h0040_0000 + 32'(4 * (40 + k)); cm_target = 32'h0060_0000;
         if (k == 4) begin
            #1;
            check("full_id_ready", id_ready, 1'b0);
         end
         tick();
      end
      idle_inputs();
      clear_stats();
      for (int k = 0; k < 6; k++) tick();
      check("drain_count", wq.size(), 4);
      for (int k = 0; k < 4 && k < wq.size(); k++) check("drain_order", wq[k], k + 1);

      // Queued install squashed by a commit invalidate to the same line
      clear_stats();
      id_valid = 1; id_pc = 32'h0040_0010; id_target = 32'h0040_0100;
      cm_valid = 1; cm_pc = 32'h0040_0020; cm_target = 32'h0040_0200;
      tick();
      idle_inputs();
      cm_valid = 1; cm_invalidate = 1; cm_pc = 32'h0040_0010; cm_target = 32'h0040_0300;
      tick();
      idle_inputs();
      for (int k = 0; k < 4; k++) tick();
      c4 = 0; v4 = 0;
      foreach (wq[k]) if (wq[k] == 4) begin c4++; if (wvq[k] === 1'b1) v4++; end
      check("squash_idx4_writes", c4, 1);
      check("squash_idx4_valid1", v4, 0);
      check("squash_total_writes", n_wr, 2);

      // Full flush walk, with requests pending throughout
      clear_stats();
      flush_req = 1;
      tick();
      flush_req = 0;
      cm_valid = 1; cm_pc = 32'h0040_0044; id_valid = 1; id_pc = 32'h0040_0048;
      run_flush_to_end();
      idle_inputs();
      check("flush_busy_cycles", n_busy, BTB);
      check("flush_writes", n_wr, BTB);
      check("flush_cm_ready_high", n_cmr, 0);
      bad = 0;
      foreach (hits[k]) if (hits[k] != 1) bad++;
      check("flush_each_index_once", bad, 0);
      for (int k = 0; k < 3; k++) tick();

      // Flush restarted at walk index 30
      clear_stats();
      flush_req = 1;
      tick();
      flush_req = 0;
      for (int k = 0; k < 100 && m_cnt != 30; k++) tick();
      flush_req = 1;
      tick();
      flush_req = 0;
      run_flush_to_end();
      check("restart_writes", n_wr, 94);
      for (int k = 0; k < 2; k++) tick();

      // Reset in the middle of a walk
      flush_req = 1;
      tick();
      flush_req = 0;
      for (int k = 0; k < 100 && m_cnt != 10; k++) tick();
      rst = 1'b0;
      #1;
      check("midrst_btb_we", btb_we, 1'b0);
      check("midrst_btb_index", btb_index, 6'd0);
      check("midrst_flush_busy", flush_busy, 1'b0);
      check("midrst_cm_ready", cm_ready, 1'b0);
      check("midrst_id_ready", id_ready, 1'b0);
      model_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      clear_stats();
      for (int k = 0; k < 80; k++) tick();
      check("post_rst_writes", n_wr, 0);

      // Random traffic on a handful of lines
      for (int k = 0; k < 400; k++) begin
         id_valid      = ($urandom_range(0, 1) == 1);
         id_is_jump    = ($urandom_range(0, 1) == 1);
         id_pc         = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2);
         id_target     = $urandom;
         cm_valid      = ($urandom_range(0, 3) == 0);
         cm_invalidate = ($urandom_range(0, 1) == 1);
         cm_is_jump    = ($urandom_range(0, 1) == 1);
         cm_pc         = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2);
         cm_target     = $urandom;
         flush_req     = ($urandom_range(0, 149) == 0);
         tick();
      end
      idle_inputs();
      for (int k = 0; k < 80; k++) tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
